// File: rtl/shift_pkg.sv
// Shared types and helpers for the shift arbiter.
// Request bundle, op encoding and bit reversal.
package shift_pkg;

  localparam int DATA_W  = 32;
  localparam int SHAMT_W = 5;
  localparam int ID_W    = 2;

  typedef enum logic [1:0] {
    SH_SLL,
    SH_SRL,
    SH_SRA,
    SH_RSV
  } shift_op_e;

  typedef struct packed {
    logic [DATA_W-1:0]  data;
    logic [SHAMT_W-1:0] shamt;
    shift_op_e          op;
    logic [ID_W-1:0]    id;
  } shift_req_t;

  function automatic logic [DATA_W-1:0] bitrev(
    input logic [DATA_W-1:0] x
  );
    logic [DATA_W-1:0] r;
    for (int i = 0; i < DATA_W; i++)
      r[i] = x[DATA_W-1-i];
    return r;
  endfunction

endpackage

// File: rtl/shift_arb_shifter.sv
// Log-depth right shifter with a selectable fill bit.
// Five mux stages, one per shamt bit.
module shifter_r_fill
  import shift_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0]   a,
  input  logic [SHAMT_W-1:0] shamt,
  input  logic               fill,
  output logic [WIDTH-1:0]   y
);

  logic [WIDTH-1:0] st [SHAMT_W+1];

  assign st[0] = a;

  for (genvar i = 0; i < SHAMT_W; i++) begin : g_st
    localparam int S = 1 << i;
    assign st[i+1] = shamt[i]
      ? {{S{fill}}, st[i][WIDTH-1:S]}
      : st[i];
  end

  assign y = st[SHAMT_W];

endmodule

// File: rtl/shift_arb.sv
// Round-robin front end sharing one right shifter
// between requesters, with a 2-stage tagged response.
module shift_arb
  import shift_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int NREQ  = 2,
  localparam int IDW  = $clog2(NREQ)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NREQ-1:0]         req_valid,
  output logic [NREQ-1:0]         req_ready,
  input  logic [NREQ*WIDTH-1:0]   req_data,
  input  logic [NREQ*SHAMT_W-1:0] req_shamt,
  input  logic [NREQ*2-1:0]       req_op,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [WIDTH-1:0]        rsp_data,
  output logic [IDW-1:0]          rsp_id,
  output logic                    rsp_err
);

  shift_req_t       s1;
  logic             s1_v;
  logic             adv2;
  logic             s1_free;
  logic             hs;
  logic [NREQ-1:0]  grant;
  logic [IDW-1:0]   ptr;
  logic [IDW-1:0]   gid;
  logic [WIDTH-1:0] core_a;
  logic [WIDTH-1:0] core_y;
  logic [WIDTH-1:0] res;
  logic             fill;

  assign adv2      = s1_v & (~rsp_valid | rsp_ready);
  assign s1_free   = ~s1_v | adv2;
  assign req_ready = grant & {NREQ{s1_free & rst_n}};
  assign hs        = |(req_valid & req_ready);

  // Scan from the far end so the nearest valid to ptr wins.
  always_comb begin
    int idx;
    grant = '0;
    gid   = '0;
    idx   = 0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      idx = int'(ptr) + k;
      if (idx >= NREQ)
        idx = idx - NREQ;
      if (req_valid[idx]) begin
        grant      = '0;
        grant[idx] = 1'b1;
        gid        = IDW'(idx);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_v <= 1'b0;
      s1   <= '0;
      ptr  <= '0;
    end else if (hs) begin
      s1_v     <= 1'b1;
      s1.data  <= req_data[int'(gid)*WIDTH +: WIDTH];
      s1.shamt <= req_shamt[int'(gid)*SHAMT_W +: SHAMT_W];
      s1.op    <= shift_op_e'(req_op[int'(gid)*2 +: 2]);
      s1.id    <= ID_W'(gid);
      ptr      <= (gid == IDW'(NREQ - 1)) ? '0 : gid + 1'b1;
    end else if (adv2) begin
      s1_v <= 1'b0;
    end
  end

  // SLL rides the right shifter by reversing in and out.
  always_comb begin
    core_a = (s1.op == SH_SLL) ? bitrev(s1.data) : s1.data;
    fill   = (s1.op == SH_SRA) & s1.data[WIDTH-1];
    res    = (s1.op == SH_SLL) ? bitrev(core_y) : core_y;
  end

  shifter_r_fill #(
    .WIDTH (WIDTH)
  ) u_shf (
    .a     (core_a),
    .shamt (s1.shamt),
    .fill  (fill),
    .y     (core_y)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
      rsp_id    <= '0;
      rsp_err   <= 1'b0;
    end else if (adv2) begin
      rsp_valid <= 1'b1;
      rsp_data  <= res;
      rsp_id    <= IDW'(s1.id);
      rsp_err   <= (s1.op == SH_RSV);
    end else if (rsp_ready) begin
      rsp_valid <= 1'b0;
    end
  end

endmodule
